instr_feeder: RTL and testbench

- Upstream neighbour of the processor control FSM.
- Walks a program counter over an external synchronous instruction ROM and drives the processor's DIN and run inputs. Watches the processor's state and Done outputs.
- Supplies the immediate word during mvi. Skips NOP opcodes and stops on HALT.
- Sits between the program ROM and the processor in the top level.

---
 rtl/instr_feeder_if.sv | 23 ++
 rtl/instr_feeder.sv | 136 +++++++++++++
 tb/tb_instr_feeder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_feeder_if.sv
// Bus between the instruction feeder, its program ROM and the processor.
// master = feeder side, slave = ROM/processor side.
interface instr_feeder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [3:0]        cpu_state;
    logic              cpu_done;
    logic [DATA_W-1:0] din;
    logic              run;

    modport master (
        output rom_addr, din, run,
        input  rom_data, cpu_state, cpu_done
    );

    modport slave (
        input  rom_addr, din, run,
        output rom_data, cpu_state, cpu_done
    );
endinterface

// File: rtl/instr_feeder.sv
// instr_feeder: walks a PC over a synchronous program ROM, presents each
// instruction word on the processor DIN, pulses run for one cycle, supplies
// the mvi immediate, skips NOPs and stops on HALT.
module instr_feeder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    instr_feeder_if.master    bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [3:0] CPU_FETCH = 4'b0001;
    localparam logic [2:0] OP_MVI    = 3'b001;
    localparam logic [2:0] OP_HALT   = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_CAP,
        S_PRES,
        S_RUN,
        S_IMM_ADDR,
        S_IMM_CAP,
        S_WAIT_DONE,
        S_HALT
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [DATA_W-1:0] din_q;
    logic              halted_q;
    logic              mvi_q;     // current instruction is mvi (din is later overwritten by the immediate)
    logic              stall_q;   // processor left fetch while in RUN; PRES must be repeated
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;
    logic              fetch_ok;
    logic [2:0]        op;
    logic              is_nop;

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign fetch_ok = (bus.cpu_state == CPU_FETCH);
    assign op       = din_q[8:6];
    assign is_nop   = op[2] && (op != OP_HALT);

    // Completion values: mvi consumes two words, retire count saturates at all-ones
    always_comb begin
        pc_d      = mvi_q ? (pc_q + ADDR_W'(2)) : pc_plus1;
        retired_d = (&retired_q) ? retired_q : (retired_q + CNT_W'(1));
    end

    // Sequencer: fetch, present, issue, immediate supply and completion tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            din_q     <= '0;
            halted_q  <= 1'b0;
            mvi_q     <= 1'b0;
            stall_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) state_q <= S_ADDR;
                end
                S_ADDR: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    din_q   <= bus.rom_data;
                    state_q <= S_PRES;
                end
                S_PRES: begin
                    // Decode only once the processor is in fetch and has seen din
                    if (fetch_ok) begin
                        if (op == OP_HALT) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else if (is_nop) begin
                            pc_q    <= pc_plus1;
                            state_q <= S_ADDR;
                        end else begin
                            mvi_q   <= (op == OP_MVI);
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!fetch_ok) begin
                        stall_q <= 1'b1;
                    end else if (stall_q) begin
                        stall_q <= 1'b0;
                        state_q <= S_PRES;
                    end else begin
                        state_q <= mvi_q ? S_IMM_ADDR : S_WAIT_DONE;
                    end
                end
                S_IMM_ADDR: begin
                    state_q <= S_IMM_CAP;
                end
                S_IMM_CAP: begin
                    din_q   <= bus.rom_data;
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.cpu_done) begin
                        pc_q      <= pc_d;
                        retired_q <= retired_d;
                        state_q   <= en ? S_ADDR : S_IDLE;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ROM address looks one word ahead only while fetching the immediate
    assign bus.rom_addr = (state_q == S_IMM_ADDR) ? pc_plus1 : pc_q;
    assign bus.run      = (state_q == S_RUN) && fetch_ok && !stall_q;
    assign bus.din      = din_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign retired      = retired_q;
endmodule

// File: tb/tb_instr_feeder.sv
// Testbench for instr_feeder: ROM and processor models, opcode table,
// directed multi-cycle sequences and randomized programs vs. an
// instruction-level reference model.
module tb_instr_feeder;
    localparam logic [3:0] FETCH = 4'b0001;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic en2 = 1'b0;
    logic cstall = 1'b0;
    logic xdone = 1'b0;
    logic mon_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // ---------------- main instance, ADDR_W = 5 ----------------
    instr_feeder_if #(.ADDR_W(5), .DATA_W(9)) bus ();
    logic [4:0] pc;
    logic       halted;
    logic [7:0] retired;

    instr_feeder #(.ADDR_W(5), .DATA_W(9), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus),
        .pc(pc), .halted(halted), .retired(retired)
    );

    logic [8:0] rom [32];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // Processor model: captures on run in fetch; mvi takes 3 cycles, others 2; Done in the last
    logic [3:0] cst;
    int         csteps;
    assign bus.cpu_state = cstall ? 4'b1000 : cst;
    assign bus.cpu_done  = ((cst != FETCH) && (csteps == 1)) || xdone;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst <= FETCH; csteps <= 0;
        end else if (cst == FETCH) begin
            if (bus.run) begin
                cst    <= (bus.din[8:6] == 3'b001) ? 4'b0100 : 4'b0010;
                csteps <= (bus.din[8:6] == 3'b001) ? 3 : 2;
            end
        end else begin
            csteps <= csteps - 1;
            if (csteps == 1) cst <= FETCH;
        end
    end

    // ---------------- second instance, ADDR_W = 2 ----------------
    instr_feeder_if #(.ADDR_W(2), .DATA_W(9)) bus2 ();
    logic [1:0] pc2;
    logic       halted2;
    logic [7:0] retired2;

    instr_feeder #(.ADDR_W(2), .DATA_W(9), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .bus(bus2),
        .pc(pc2), .halted(halted2), .retired(retired2)
    );

    logic [8:0] rom2 [4];
    always @(posedge clk) bus2.rom_data <= rom2[bus2.rom_addr];

    logic [3:0] cst2;
    int         csteps2;
    assign bus2.cpu_state = cst2;
    assign bus2.cpu_done  = (cst2 != FETCH) && (csteps2 == 1);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst2 <= FETCH; csteps2 <= 0;
        end else if (cst2 == FETCH) begin
            if (bus2.run) begin
                cst2    <= (bus2.din[8:6] == 3'b001) ? 4'b0100 : 4'b0010;
                csteps2 <= (bus2.din[8:6] == 3'b001) ? 3 : 2;
            end
        end else begin
            csteps2 <= csteps2 - 1;
            if (csteps2 == 1) cst2 <= FETCH;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        en = 0; en2 = 0; cstall = 0; xdone = 0; mon_en = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
    endtask

    task automatic fill(input logic [8:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    // Instruction-level reference: the ordered list of issued instructions
    typedef struct {
        logic [4:0] pc;
        logic [8:0] word;
        logic [8:0] imm;
        logic       mvi;
    } ins_t;
    ins_t exp_q[$];
    ins_t cur;
    int   halt_pc;

    function automatic void build_model();
        int   p;
        ins_t e;
        p = 0;
        halt_pc = -1;
        exp_q.delete();
        for (int guard = 0; guard < 100; guard++) begin
            if (rom[p][8:6] == 3'b111) begin
                halt_pc = p;
                break;
            end else if (rom[p][8] == 1'b1) begin
                p = (p + 1) % 32;
            end else begin
                e.pc   = 5'(p);
                e.word = rom[p];
                e.imm  = rom[(p + 1) % 32];
                e.mvi  = (rom[p][8:6] == 3'b001);
                exp_q.push_back(e);
                p = (p + (e.mvi ? 2 : 1)) % 32;
            end
        end
    endfunction

    // Transaction monitor for the randomized programs
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.run) begin
                if (exp_q.size() == 0) begin
                    chk("R_extra_issue", exp_q.size(), 1);
                end else begin
                    cur = exp_q.pop_front();
                    chk("R_issue_pc", pc, cur.pc);
                    chk("R_issue_din", bus.din, cur.word);
                end
            end
            if (bus.cpu_done) chk("R_done_din", bus.din, cur.mvi ? cur.imm : cur.word);
        end
    end

    // ---------------- opcode table ----------------
    typedef struct {
        logic [8:0] word;
        logic [8:0] imm;
        int         runs;
        logic [4:0] pc;
        logic [7:0] ret;
        logic       halt;
        logic [8:0] din;
    } vec_t;
    vec_t tbl[9];

    int         runk[$];
    logic [8:0] rund[$];
    int         nrun;
    logic [31:0] mask;
    logic [8:0] dn_din;
    int         expk[3];
    logic [8:0] expw[3];

    initial begin
        tbl[0] = '{9'h008, 9'h1C0, 1, 5'd1, 8'd1, 1'b0, 9'h008}; // mv
        tbl[1] = '{9'h040, 9'h0C3, 1, 5'd2, 8'd1, 1'b0, 9'h0C3}; // mvi
        tbl[2] = '{9'h081, 9'h1C0, 1, 5'd1, 8'd1, 1'b0, 9'h081}; // add
        tbl[3] = '{9'h0C1, 9'h1C0, 1, 5'd1, 8'd1, 1'b0, 9'h0C1}; // sub
        tbl[4] = '{9'h100, 9'h1C0, 0, 5'd1, 8'd0, 1'b1, 9'h1C0}; // NOP 100
        tbl[5] = '{9'h155, 9'h1C0, 0, 5'd1, 8'd0, 1'b1, 9'h1C0}; // NOP 101
        tbl[6] = '{9'h1AA, 9'h1C0, 0, 5'd1, 8'd0, 1'b1, 9'h1C0}; // NOP 110
        tbl[7] = '{9'h1FF, 9'h000, 0, 5'd0, 8'd0, 1'b1, 9'h1FF}; // HALT
        tbl[8] = '{9'h040, 9'h1C0, 1, 5'd2, 8'd1, 1'b0, 9'h1C0}; // mvi, immediate looks like HALT

        // Reset state, checked while reset is held
        @(negedge clk); rst_n = 0; #1;
        chk("rst_pc", pc, 0);
        chk("rst_din", bus.din, 0);
        chk("rst_run", bus.run, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);

        // Table: one instruction from address 0, en only for the first cycle
        for (int t = 0; t < 9; t++) begin
            fill(9'h1C0);
            rom[0] = tbl[t].word;
            rom[1] = tbl[t].imm;
            do_reset();
            en = 1;
            nrun = 0;
            for (int k = 1; k <= 24; k++) begin
                @(negedge clk);
                en = 0;
                if (bus.run) nrun++;
            end
            chk("T_runs", nrun, tbl[t].runs);
            chk("T_pc", pc, tbl[t].pc);
            chk("T_retired", retired, tbl[t].ret);
            chk("T_halted", halted, tbl[t].halt);
            chk("T_din", bus.din, tbl[t].din);
        end

        // A: mvi, mv, add, NOP, HALT program
        fill(9'h1C0);
        rom[0] = 9'h040; rom[1] = 9'd5; rom[2] = 9'h008;
        rom[3] = 9'h081; rom[4] = 9'h100; rom[5] = 9'h1C0;
        expk = '{4, 11, 17};
        expw = '{9'h040, 9'h008, 9'h081};
        do_reset();
        en = 1;
        runk.delete(); rund.delete();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.run) begin runk.push_back(k); rund.push_back(bus.din); end
            if (k == 5) chk("A_imm_addr", bus.rom_addr, 1);
            if (k == 7) begin
                chk("A_imm_din", bus.din, 5);
                chk("A_imm_done", bus.cpu_done, 1);
            end
            if (k == 8) begin
                chk("A_pc_mvi", pc, 2);
                chk("A_ret_mvi", retired, 1);
            end
            if (k == 20) begin
                chk("A_pc_add", pc, 4);
                chk("A_ret_add", retired, 3);
            end
        end
        chk("A_nruns", runk.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("A_run_cycle", (i < runk.size()) ? runk[i] : -1, expk[i]);
            chk("A_run_word", (i < rund.size()) ? rund[i] : 9'h0, expw[i]);
        end
        chk("A_pc_halt", pc, 5);
        chk("A_halted", halted, 1);
        chk("A_ret_halt", retired, 3);
        en = 0;
        repeat (8) @(negedge clk);
        chk("A_halt_sticky", halted, 1);
        chk("A_halt_pc_hold", pc, 5);
        chk("A_halt_run", bus.run, 0);

        // B: asynchronous reset while in IMM_CAP, then restart from address 0
        do_reset();
        en = 1;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        chk("B_din_before", bus.din, 9'h040);
        #1 rst_n = 0;
        #1;
        chk("B_async_din", bus.din, 0);
        chk("B_async_run", bus.run, 0);
        chk("B_async_pc", pc, 0);
        chk("B_async_rom_addr", bus.rom_addr, 0);
        chk("B_async_halted", halted, 0);
        chk("B_async_retired", retired, 0);
        @(negedge clk); rst_n = 1;
        runk.delete(); rund.delete();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (bus.run) begin runk.push_back(k); rund.push_back(bus.din); end
            if (k == 5) chk("B_restart_imm_addr", bus.rom_addr, 1);
        end
        chk("B_restart_cycle", (runk.size() > 0) ? runk[0] : -1, 4);
        chk("B_restart_word", (rund.size() > 0) ? rund[0] : 9'h0, 9'h040);

        // C: en dropped in WAIT_DONE, then resumed at the new pc
        fill(9'h1C0);
        rom[0] = 9'h008; rom[1] = 9'h081;
        do_reset();
        en = 1;
        nrun = 0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k >= 7 && k <= 12 && bus.run) nrun++;
            if (k == 7) begin
                chk("C_pc_idle", pc, 1);
                chk("C_ret_idle", retired, 1);
            end
            if (k == 16) begin
                chk("C_resume_run", bus.run, 1);
                chk("C_resume_din", bus.din, 9'h081);
                chk("C_resume_pc", pc, 1);
            end
            if (k == 19) begin
                chk("C_pc_after", pc, 2);
                chk("C_ret_after", retired, 2);
            end
            if (k == 5) en = 0;
            if (k == 12) en = 1;
        end
        chk("C_idle_no_run", nrun, 0);

        // D: cpu_done outside WAIT_DONE is ignored
        do_reset();
        en = 1;
        xdone = 1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 4) begin
                chk("D_pc_early", pc, 0);
                chk("D_ret_early", retired, 0);
                chk("D_run", bus.run, 1);
            end
            if (k == 7) begin
                chk("D_pc_done", pc, 1);
                chk("D_ret_done", retired, 1);
            end
            xdone = (k < 4);
        end

        // E: processor leaves fetch during RUN -> run drops, PRES is redone
        do_reset();
        en = 1;
        mask = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.run) mask[k] = 1'b1;
            if (k == 10) begin
                chk("E_pc", pc, 1);
                chk("E_ret_once", retired, 1);
            end
            cstall = (k == 4);
        end
        chk("E_run_mask", mask, 32'h90);

        // F: ADDR_W=2, mvi at the top address reads its immediate from address 0
        rom2[0] = 9'h100; rom2[1] = 9'h100; rom2[2] = 9'h100; rom2[3] = 9'h040;
        do_reset();
        en2 = 1;
        dn_din = 9'h0;
        nrun = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            en2 = 0;
            if (bus2.run) begin
                nrun++;
                chk("F_issue_pc", pc2, 3);
            end
            if (bus2.cpu_done) dn_din = bus2.din;
        end
        chk("F_runs", nrun, 1);
        chk("F_imm_wrap", dn_din, 9'h100);
        chk("F_pc_wrap", pc2, 1);
        chk("F_retired", retired2, 1);
        chk("F_halted", halted2, 0);

        // Randomized programs against the instruction-level model
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 30; i++) rom[i] = 9'($urandom_range(0, 511));
            rom[30] = 9'h1C0; rom[31] = 9'h1C0;
            build_model();
            do_reset();
            mon_en = 1;
            for (int c = 0; c < 4000; c++) begin
                @(posedge clk); #1;
                cstall = ($urandom_range(0, 3) == 0);
                en     = ($urandom_range(0, 3) != 0);
                if (halted) break;
            end
            @(negedge clk);
            mon_en = 0; cstall = 0;
            chk("R_halted", halted, 1);
            chk("R_halt_pc", pc, 32'(halt_pc));
            chk("R_leftover", exp_q.size(), 0);
        end

        // Retired counter saturation: endless stream of mv
        fill(9'h008);
        do_reset();
        en = 1;
        repeat (1700) @(negedge clk);
        chk("S_sat", retired, 8'hFF);
        repeat (20) @(negedge clk);
        chk("S_sat_hold", retired, 8'hFF);
        chk("S_not_halted", halted, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
